// File: rtl/dual_pol_acc_unpack_if.sv
// Stream bundle for the dual-pol accumulator unpacker: packed vector input
// side plus the serialised complex-word output side.
interface dual_pol_acc_unpack_if #(
  parameter int unsigned ACC_BITS = 19
);
  logic [8*ACC_BITS-1:0] acc_in;
  logic                  valid_in;
  logic                  sync_in;
  logic [2*ACC_BITS-1:0] out_data;
  logic [1:0]            out_pol;
  logic                  out_sync;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output acc_in, valid_in, sync_in, out_ready,
    input  out_data, out_pol, out_sync, out_valid
  );

  modport slave (
    input  acc_in, valid_in, sync_in, out_ready,
    output out_data, out_pol, out_sync, out_valid
  );
endinterface

// File: rtl/dual_pol_acc_unpack.sv
// Captures packed XX/YY/XY/YX accumulator vectors into a 2-entry buffer and
// streams them out one complex word per polarisation product.
module dual_pol_acc_unpack #(
  parameter int unsigned BITWIDTH            = 4,
  parameter int unsigned P_FACTOR_BITS       = 3,
  parameter int unsigned SERIAL_ACC_LEN_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_pol_acc_unpack_if.slave  bus,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int unsigned ACC_BITS = 2*BITWIDTH + 1 + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS;
  localparam int unsigned CPX_W    = 2*ACC_BITS;
  localparam int unsigned VEC_W    = 8*ACC_BITS;
  localparam int unsigned ENT_W    = VEC_W + 1;

  logic [ENT_W-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic [1:0]       r_word;
  logic [CPX_W-1:0] r_out_data;
  logic [1:0]       r_out_pol;
  logic             r_out_sync;
  logic             r_out_valid;
  logic             r_overflow;
  logic [15:0]      r_drop_count;

  logic [ENT_W-1:0] w_head;
  logic [CPX_W-1:0] w_chunk;
  logic             w_empty;
  logic             w_full;
  logic             w_out_free;
  logic             w_load;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_empty    = (r_count == 2'd0);
  assign w_full     = (r_count == 2'd2);
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_load     = w_out_free && !w_empty;
  assign w_pop      = w_load && (r_word == 2'd3);
  // A pop on the same edge frees a slot, so a full buffer still accepts.
  assign w_push     = !rst && bus.valid_in && (!w_full || w_pop);
  assign w_drop     = bus.valid_in && w_full && !w_pop;

  always_comb begin
    w_chunk = '0;
    unique case (r_word)
      2'd0: w_chunk = w_head[4*CPX_W-1:3*CPX_W];
      2'd1: w_chunk = w_head[3*CPX_W-1:2*CPX_W];
      2'd2: w_chunk = w_head[2*CPX_W-1:1*CPX_W];
      2'd3: w_chunk = w_head[1*CPX_W-1:0];
      default: w_chunk = '0;
    endcase
  end

  // Buffer storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.sync_in, bus.acc_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output word register; holds everything while stalled downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word      <= 2'd0;
      r_out_data  <= '0;
      r_out_pol   <= 2'd0;
      r_out_sync  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_chunk;
      r_out_pol   <= r_word;
      r_out_sync  <= w_head[VEC_W] && (r_word == 2'd0);
      r_out_valid <= 1'b1;
      r_word      <= r_word + 2'd1;
    end else if (w_out_free) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_pol   = r_out_pol;
  assign bus.out_sync  = r_out_sync;
  assign bus.out_valid = r_out_valid;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;

endmodule

// File: doc/dual_pol_acc_unpack.md
# dual_pol_acc_unpack

Readout-side companion to the dual-polarisation complex multiply-accumulator in the X-engine. It captures each packed accumulator vector (XX, YY, XY, YX complex results) when the vector is flagged valid at the end of the accumulation chain. It then serialises the vector into four complex words, one per polarisation product, on a valid/ready stream towards the vector accumulator / packetiser. A 2-entry holding buffer absorbs bursts; excess vectors are dropped and flagged.

## Interface
- BITWIDTH, 4, bits per real/imag part of one input sample
- P_FACTOR_BITS, 3, log2 of the parallel sample count in the MAC
- SERIAL_ACC_LEN_BITS, 7, log2 of the serial accumulation length in the MAC
- ACC_BITS (localparam) = 2*BITWIDTH+1+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS (19 at defaults), width of one real or imag part
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- acc_in  in  8*ACC_BITS  packed vector: [8A-1:6A] XX, [6A-1:4A] YY, [4A-1:2A] XY, [2A-1:0] YX; each chunk {real[2A-1:A], imag[A-1:0]}, A=ACC_BITS
- valid_in  in  1  acc_in valid for this cycle
- sync_in  in  1  qualified by valid_in; marks first vector of an integration
- out_data  out  2*ACC_BITS  one complex product {real, imag}, bit-exact copy of the chunk
- out_pol  out  2  0=XX, 1=YY, 2=XY, 3=YX
- out_sync  out  1  high with the XX word of a vector captured with sync_in=1
- out_valid  out  1  out_data/out_pol/out_sync valid
- out_ready  in  1  downstream accepts word when out_valid & out_ready
- overflow  out  1  sticky; set when a valid_in vector is dropped
- drop_count  out  16  count of dropped vectors, saturates at 0xFFFF

## Operation
- Input buffer: 2-entry FIFO of {acc_in, sync_in}. Push on valid_in unless full. An entry is popped on the edge at which its YX word is loaded into the output register.
- valid_in while full and no pop on the same edge: vector dropped, overflow<=1, drop_count+1 (saturating). If a pop occurs on that edge, the push is accepted (simultaneous pop/push never drops).
- Serialiser: 2-bit word index w (0..3) selects a chunk of the FIFO head. Output register loads when (!out_valid | out_ready) and FIFO non-empty: out_data<=chunk w, out_pol<=w, out_sync<=head.sync & (w==0), out_valid<=1, w<=w+1 (wraps 3->0, popping the head).
- If (!out_valid | out_ready) and FIFO empty: out_valid<=0. out_data holds its last value.
- out_valid & !out_ready: all outputs hold. The word order is strictly XX, YY, XY, YX. The stream never interleaves vectors.
- No arithmetic is performed; widths pass through unchanged.
- Reset (any time, including mid-vector): FIFO emptied, w=0, out_valid=0, out_data=0, out_pol=0, out_sync=0, overflow=0, drop_count=0. valid_in is ignored during rst=1. A partially emitted vector is discarded.

## Timing
- Latency: valid_in sampled at edge E into an empty block with out_ready=1 -> XX word presented after edge E+1. YY, XY and YX follow after E+2, E+3 and E+4. The head is popped at E+4.
- Sustained throughput: 1 vector per 4 accepted words. The input may burst 2 vectors back-to-back into an empty buffer without loss.
- overflow and drop_count update on the edge that samples the dropped valid_in.
- out_ready is used only combinationally into the load enable; there is no combinational path from valid_in to outputs.

## Test plan
- Single vector: acc_in chunks XX=0x0000100001, YY=0x0000200002, XY=0x0000300003, YX=0x0000400004 with sync_in=1, out_ready=1. Required: 4 consecutive words with out_pol 0,1,2,3 and matching out_data; out_sync=1 on XX only; first word after E+1; out_valid=0 after E+5.
- Backpressure: same vector, out_ready=0 for 5 cycles after the XX word appears, then 1. Required: XX held stable for all 5 cycles; then YY, XY, YX on successive cycles; nothing lost.
- Burst overflow: valid_in at E, E+1, E+2 (vectors V0, V1, V2), out_ready=1. Required: V2 dropped; overflow=1 and drop_count=1 after E+2; output is V0's 4 words then V1's 4 words.
- Simultaneous pop/push: fill 2 entries, then assert valid_in on the edge where V0's YX word loads. Required: no drop; V2 emitted after V1; overflow stays 0.
- Reset mid-vector: assert rst for 1 cycle after the YY word of V0, with V1 buffered. Required: all outputs at reset values the next cycle; V0 and V1 never emitted; a new vector afterwards starts at out_pol=0.
- Saturation: force 65540 drops. Required: drop_count=0xFFFF; overflow=1.
